spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  Mode-0 SPI slave receiver: samples si on rising sck while cs is low.
//  Assembles data_len-bit words and presents them on a one-deep holding register with a valid/ready handshake.
//  Receive-side companion of the slave transmitter in the AXI SPI DC slave; the AXI register layer consumes dout.
// PARAMETERS
//  data_len  8  bits per frame (2..32)
// PORTS
//  clk        in   1         system clock; all logic on posedge clk
//  rst        in   1         asynchronous, active-high reset
//  rx_en      in   1         receiver enable
//  cs         in   1         chip select, active low, asynchronous to clk
//  sck        in   1         SPI clock, asynchronous to clk
//  si         in   1         serial data in (MOSI)
//  rx_ready   in   1         consumer accepts dout this cycle
//  clr_ovr    in   1         clears the sticky overrun flag
//  dout       out  data_len  received word (holding register)
//  rx_valid   out  1         dout holds an unconsumed word
//  qvld       out  1         one-cycle pulse: a word was just loaded
//  overrun    out  1         sticky: a word was overwritten before it was consumed
//  frame_err  out  1         one-cycle pulse: cs rose mid-frame
//  state_rx   out  2         current FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; bit_cnt = 0; shift register = 0.
//  Synchronisation: cs, sck and si each pass through a 2-FF synchroniser (cs_s, sck_s, si_s).
//   sck_d is one extra register of sck_s; rise = sck_s & ~sck_d.
//  Timing requirement: sck high time >= 2 clk and low time >= 2 clk (f_clk >= 4*f_sck); below that, behaviour is undefined.
//  FSM (state_rx encoding): IDLE=0, SHIFT=1, DONE=2; code 3 returns to IDLE.
//   IDLE:  bit_cnt <= 0; go to SHIFT when rx_en & ~cs_s.
//   SHIFT: on rise, shreg <= {shreg[data_len-2:0], si_s} and bit_cnt++.
//          On rise with bit_cnt == data_len-1, go to DONE.
//          If cs_s == 1 with 0 < bit_cnt < data_len: frame_err = 1 for one cycle, discard the partial word, go to IDLE.
//          If cs_s == 1 with bit_cnt == 0: go to IDLE silently.
//   DONE (1 cycle): dout <= shreg; rx_valid <= 1; qvld = 1; bit_cnt <= 0.
//          Next state is SHIFT if ~cs_s & rx_en (back-to-back frames), else IDLE.
//  Latency: qvld/rx_valid assert 4 clk edges after the last sck rising edge at the pin (+1 for asynchronous alignment).
//  Handshake: rx_valid & rx_ready in a cycle with no load clears rx_valid next cycle.
//  Simultaneous load in DONE and accept (rx_valid & rx_ready): the new word loads, rx_valid stays 1, overrun is not set.
//  Load in DONE while rx_valid & ~rx_ready: the word is overwritten and overrun <= 1.
//  overrun clears on clr_ovr; set wins over clr_ovr in the same cycle.
//  rx_en = 0: FSM forced to IDLE, partial word discarded, no frame_err.
//   dout, rx_valid and overrun are retained and the handshake keeps working.
//  Reset mid-frame: everything returns to reset values immediately; no pulses are generated.
//  Arithmetic: bit_cnt is $clog2(data_len+1) bits and never exceeds data_len-1.
// CONFIGURATION
//  SPI_RX_LSB_FIRST_EN defined: shreg <= {si_s, shreg[data_len-1:1]}; the first bit received lands in dout[0].
//  SPI_RX_LSB_FIRST_EN undefined (default): MSB first, as specified above; the first bit received lands in dout[data_len-1].
// STRUCTURE
//  spi_pkg (shared with the transmitter): FSM state localparams (RX_IDLE, RX_SHIFT, RX_DONE) and SPI_SYNC_STAGES = 2.
//  Sub-module spi_sync_2ff: 1-bit synchroniser with async reset value. Instantiate it three times (cs resets to 1, sck to 0, si to 0).
// TESTING
//  Send 0xA5 MSB-first, f_clk = 8*f_sck -> dout = 8'hA5, rx_valid = 1, a single qvld pulse, latency 4-5 clk after the 8th rise.
//  Send 0x3C then 0xC3 back-to-back under one cs low, rx_ready held 1 -> two qvld pulses, dout 0x3C then 0xC3, overrun stays 0.
//  Send 0x11 then 0x22 with rx_ready = 0 -> dout = 0x22 and overrun = 1; pulse clr_ovr -> overrun = 0.
//  Raise cs after 5 bits -> one frame_err pulse, no qvld, dout unchanged; the next full frame 0x5A is received correctly.
//  Assert rst after 4 bits -> all outputs 0; a frame 0xFF after release gives dout = 0xFF.
//  With SPI_RX_LSB_FIRST_EN defined, send the bit sequence 1,0,0,0,0,0,0,0 -> dout = 8'h01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM state encoding and synchroniser depth.
// Used by the slave receiver and the slave transmitter.
package spi_pkg;

  localparam int SPI_SYNC_STAGES = 2;

  // Encoding is visible on the state_rx debug port, so values are fixed.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_sync_2ff.sv
// Single-bit multi-flop synchroniser for signals asynchronous to clk.
// The reset value is a parameter so an idle-high line (chip select) powers up inactive.
module spi_sync_2ff
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SPI_SYNC_STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {SPI_SYNC_STAGES{RST_VAL}};
    end else begin
      ff <= {ff[SPI_SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave receiver with a one-deep valid/ready holding register.
// Define SPI_RX_LSB_FIRST_EN to shift LSB first; the default build is MSB first.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int data_len = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_en,
  input  logic                cs,
  input  logic                sck,
  input  logic                si,
  input  logic                rx_ready,
  input  logic                clr_ovr,
  output logic [data_len-1:0] dout,
  output logic                rx_valid,
  output logic                qvld,
  output logic                overrun,
  output logic                frame_err,
  output logic [1:0]          state_rx
);

  localparam int            CW       = $clog2(data_len + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(data_len - 1);

  logic                cs_s;
  logic                sck_s;
  logic                si_s;
  logic                sck_d;
  logic                sck_rise;
  rx_state_t           state;
  logic [CW-1:0]       bit_cnt;
  logic [data_len-1:0] shreg;
  logic [data_len-1:0] shreg_next;

  spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs),
    .q   (cs_s)
  );

  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (sck),
    .q   (sck_s)
  );

  spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_si (
    .clk (clk),
    .rst (rst),
    .d   (si),
    .q   (si_s)
  );

  // si_s shares the sck_s pipeline depth, so it is aligned with the detected edge.
  assign sck_rise = sck_s & ~sck_d;

`ifdef SPI_RX_LSB_FIRST_EN
  assign shreg_next = {si_s, shreg[data_len-1:1]};
`else
  assign shreg_next = {shreg[data_len-2:0], si_s};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      sck_d     <= 1'b0;
      dout      <= '0;
      rx_valid  <= 1'b0;
      qvld      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_d     <= sck_s;
      qvld      <= 1'b0;
      frame_err <= 1'b0;

      // Holding register: a load takes priority over an accept in the same cycle.
      if (state == RX_DONE) begin
        dout     <= shreg;
        rx_valid <= 1'b1;
        qvld     <= 1'b1;
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else if (clr_ovr) begin
          overrun <= 1'b0;
        end
      end else begin
        if (rx_valid && rx_ready) begin
          rx_valid <= 1'b0;
        end
        if (clr_ovr) begin
          overrun <= 1'b0;
        end
      end

      case (state)
        RX_IDLE: begin
          bit_cnt <= '0;
          if (rx_en && !cs_s) begin
            state <= RX_SHIFT;
          end
        end

        RX_SHIFT: begin
          if (!rx_en) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
          end else if (cs_s) begin
            // A frame ending between words is normal; only a partial word is an error.
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
            state   <= RX_IDLE;
            bit_cnt <= '0;
          end else if (sck_rise) begin
            shreg <= shreg_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= RX_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        RX_DONE: begin
          bit_cnt <= '0;
          if (rx_en && !cs_s) begin
            state <= RX_SHIFT;
          end else begin
            state <= RX_IDLE;
          end
        end

        // NOTE: the unused code 3 must still have a defined next state so a
        // corrupted state register recovers instead of locking up.
        default: begin
          state   <= RX_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign state_rx = state;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed self-checking bench for spi_slave_rx (data_len = 8, f_clk = 8 * f_sck).
// Expected words follow the bit order selected by SPI_RX_LSB_FIRST_EN.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       cs = 1'b1;
  logic       sck = 1'b0;
  logic       si = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] dout;
  logic       rx_valid;
  logic       qvld;
  logic       overrun;
  logic       frame_err;
  logic [1:0] state_rx;

  int         errors = 0;
  int         checks = 0;

  int         qvld_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] got_q[$];
  longint     qvld_time = 0;
  longint     last_rise = 0;

  spi_slave_rx #(.data_len(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .cs        (cs),
    .sck       (sck),
    .si        (si),
    .rx_ready  (rx_ready),
    .clr_ovr   (clr_ovr),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .qvld      (qvld),
    .overrun   (overrun),
    .frame_err (frame_err),
    .state_rx  (state_rx)
  );

  always #5 clk = ~clk;

  // Pulse monitor: samples 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (qvld) begin
      qvld_cnt  = qvld_cnt + 1;
      qvld_time = $time;
      got_q.push_back(dout);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  function automatic logic [7:0] exp_word(input logic [7:0] sent);
`ifdef SPI_RX_LSB_FIRST_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = sent[7-i];
    return r;
`else
    return sent;
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; one sck period is 8 clk.
  task automatic send_bit(input logic b);
    si = b;
    #40;
    sck = 1'b1;
    last_rise = $time;
    #40;
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    wait_clk(3);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if ({rx_valid, qvld, overrun, frame_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {rx_valid, qvld, overrun, frame_err}); end
    checks++; if (state_rx !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_rx); end
    rst = 1'b0;
    rx_en = 1'b1;
    wait_clk(3);
  endtask

  task automatic test_single;
    int q0, f0;
    longint lat;
    q0 = qvld_cnt; f0 = ferr_cnt;
    cs = 1'b0;
    wait_clk(4);
    checks++; if (state_rx !== 2'd1) begin errors++; $display("FAIL single_state_shift got=%0d exp=1", state_rx); end
    send_word(8'hA5);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
    lat = (qvld_time - last_rise - 5) / 10 + 1;
    checks++; if (dout !== exp_word(8'hA5)) begin errors++; $display("FAIL single_dout got=%h exp=%h", dout, exp_word(8'hA5)); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rx_valid); end
    checks++; if (qvld_cnt - q0 !== 1) begin errors++; $display("FAIL single_qvld_count got=%0d exp=1", qvld_cnt - q0); end
    checks++; if (lat < 4 || lat > 5) begin errors++; $display("FAIL single_latency got=%0d exp=4..5", lat); end
    checks++; if (ferr_cnt - f0 !== 0 || overrun !== 1'b0) begin errors++; $display("FAIL single_no_err ferr=%0d ovr=%b exp=0/0", ferr_cnt - f0, overrun); end
    checks++; if (state_rx !== 2'd0) begin errors++; $display("FAIL single_state_idle got=%0d exp=0", state_rx); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_accept got=%b exp=0", rx_valid); end
    checks++; if (dout !== exp_word(8'hA5)) begin errors++; $display("FAIL single_dout_kept got=%h exp=%h", dout, exp_word(8'hA5)); end
  endtask

  task automatic test_back_to_back;
    int q0, f0;
    q0 = qvld_cnt; f0 = ferr_cnt;
    rx_ready = 1'b1;
    cs = 1'b0;
    wait_clk(4);
    send_word(8'h3C);
    send_word(8'hC3);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
    checks++; if (qvld_cnt - q0 !== 2) begin errors++; $display("FAIL b2b_qvld_count got=%0d exp=2", qvld_cnt - q0); end
    if (qvld_cnt - q0 == 2) begin
      checks++; if (got_q[q0] !== exp_word(8'h3C)) begin errors++; $display("FAIL b2b_word0 got=%h exp=%h", got_q[q0], exp_word(8'h3C)); end
      checks++; if (got_q[q0+1] !== exp_word(8'hC3)) begin errors++; $display("FAIL b2b_word1 got=%h exp=%h", got_q[q0+1], exp_word(8'hC3)); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", rx_valid); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err got=%0d exp=0", ferr_cnt - f0); end
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun;
    @(negedge clk);
    cs = 1'b0;
    wait_clk(4);
    send_word(8'h11);
    send_word(8'h22);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
    checks++; if (dout !== exp_word(8'h22)) begin errors++; $display("FAIL ovr_dout got=%h exp=%h", dout, exp_word(8'h22)); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    wait_clk(3);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept got=%b exp=1", rx_valid); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_err;
    int q0, f0;
    logic [7:0] part;
    q0 = qvld_cnt; f0 = ferr_cnt;
    part = 8'hF0;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 7; i >= 3; i--) send_bit(part[i]);
    wait_clk(2);
    cs = 1'b1;
    wait_clk(8);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (qvld_cnt - q0 !== 0) begin errors++; $display("FAIL ferr_no_qvld got=%0d exp=0", qvld_cnt - q0); end
    checks++; if (dout !== exp_word(8'h22)) begin errors++; $display("FAIL ferr_dout_kept got=%h exp=%h", dout, exp_word(8'h22)); end
    cs = 1'b0;
    wait_clk(4);
    send_word(8'h5A);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
    checks++; if (dout !== exp_word(8'h5A)) begin errors++; $display("FAIL ferr_next_dout got=%h exp=%h", dout, exp_word(8'h5A)); end
    checks++; if (ferr_cnt - f0 !== 1 || qvld_cnt - q0 !== 1) begin errors++; $display("FAIL ferr_next_counts ferr=%0d qvld=%0d exp=1/1", ferr_cnt - f0, qvld_cnt - q0); end
  endtask

  task automatic test_rx_disable;
    int q0, f0;
    q0 = qvld_cnt; f0 = ferr_cnt;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_en = 1'b0;
    wait_clk(4);
    checks++; if (state_rx !== 2'd0) begin errors++; $display("FAIL dis_state got=%0d exp=0", state_rx); end
    cs = 1'b1;
    wait_clk(6);
    checks++; if (ferr_cnt - f0 !== 0 || qvld_cnt - q0 !== 0) begin errors++; $display("FAIL dis_pulses ferr=%0d qvld=%0d exp=0/0", ferr_cnt - f0, qvld_cnt - q0); end
    checks++; if (dout !== exp_word(8'h5A) || rx_valid !== 1'b1) begin errors++; $display("FAIL dis_retained dout=%h valid=%b exp=%h/1", dout, rx_valid, exp_word(8'h5A)); end
    rx_en = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_reset_mid_frame;
    int q0, f0;
    q0 = qvld_cnt; f0 = ferr_cnt;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    checks++; if ({dout, rx_valid, qvld, overrun, frame_err, state_rx} !== 14'd0) begin errors++; $display("FAIL rst_mid_outputs dout=%h v=%b q=%b o=%b f=%b s=%0d exp=all0", dout, rx_valid, qvld, overrun, frame_err, state_rx); end
    @(negedge clk);
    cs = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    checks++; if (ferr_cnt - f0 !== 0 || qvld_cnt - q0 !== 0) begin errors++; $display("FAIL rst_mid_pulses ferr=%0d qvld=%0d exp=0/0", ferr_cnt - f0, qvld_cnt - q0); end
    cs = 1'b0;
    wait_clk(4);
    send_word(8'hFF);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
    checks++; if (dout !== 8'hFF || rx_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_next dout=%h valid=%b exp=ff/1", dout, rx_valid); end
  endtask

  task automatic test_bit_order;
    cs = 1'b0;
    wait_clk(4);
    send_word(8'h80);
    wait_clk(10);
    cs = 1'b1;
    wait_clk(6);
`ifdef SPI_RX_LSB_FIRST_EN
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL order_lsb got=%h exp=01", dout); end
`else
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL order_msb got=%h exp=80", dout); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_rx_disable();
    test_reset_mid_frame();
    test_bit_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
